cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the CPU datapath. It sequences the flip-flop-based PC, IR, AR and register file through fetch, decode and execute by driving their load and enable strobes. It also drives the memory read/write handshake and halts on HLT, an illegal opcode or a memory timeout. It sits between the instruction register/flags and the datapath register enables.

---
 rtl/cpu_sequencer.sv | 86 ++++++++
 tb/tb_cpu_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control FSM driving datapath strobes and memory handshake
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RUN,
  input  logic [3:0]       IR_OPCODE,
  input  logic             ZERO,
  input  logic             MEM_READY,
  output logic             PC_LD,
  output logic             PC_INC,
  output logic             IR_LD,
  output logic             AR_LD,
  output logic             MEM_RD,
  output logic             MEM_WR,
  output logic             RF_WE,
  output logic             RF_SRC,
  output logic [2:0]       ALU_OP,
  output logic             HALTED,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEMADDR, MEM, BRANCH, HALT} state_t;
  state_t state;
  logic [3:0] op_q;
  logic [WW-1:0] wt;
  logic fetch, mem, st, ld_done, timeout;
  always_comb begin
    fetch = state == FETCH;
    mem = state == MEM;
    st = op_q == 4'd7;
    ld_done = mem && !st && MEM_READY;
    timeout = wt == WW'(MEM_TIMEOUT - 1) && !MEM_READY;
    PC_LD = state == BRANCH;
    PC_INC = fetch && MEM_READY;
    IR_LD = fetch && MEM_READY;
    AR_LD = state == MEMADDR;
    MEM_RD = fetch || (mem && !st);
    MEM_WR = mem && st;
    RF_WE = state == EXEC || ld_done;
    RF_SRC = ld_done;
    ALU_OP = state == EXEC ? 3'(op_q - 4'd1) : 3'd0;
    HALTED = state == HALT;
  end
  // wt is held at zero outside FETCH/MEM, so every entry to those states starts a fresh count
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      op_q <= 4'd0;
      wt <= '0;
      ERR <= 1'b0;
      INSTR_CNT <= '0;
    end else begin
      wt <= '0;
      case (state)
        IDLE: state <= RUN ? FETCH : IDLE;
        FETCH, MEM:
          if (MEM_READY) state <= fetch ? DECODE : FETCH;
          else if (timeout) begin
            state <= HALT;
            ERR <= 1'b1;
          end else wt <= wt + WW'(1);
        DECODE: begin
          op_q <= IR_OPCODE;
          INSTR_CNT <= INSTR_CNT + CNT_W'(1);
          if (IR_OPCODE == 4'd0) state <= FETCH;
          else if (IR_OPCODE <= 4'd5) state <= EXEC;
          else if (IR_OPCODE <= 4'd7) state <= MEMADDR;
          else if (IR_OPCODE == 4'd8) state <= BRANCH;
          else if (IR_OPCODE == 4'd9) state <= ZERO ? BRANCH : FETCH;
          else begin
            state <= HALT;
            ERR <= IR_OPCODE != 4'hF;
          end
        end
        EXEC: state <= FETCH;
        MEMADDR: state <= MEM;
        BRANCH: state <= FETCH;
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle vectors; expected strobes are queued by the stimulus and checked by a monitor
module tb_cpu_sequencer;
  logic CLK = 1'b0, RST_N, RUN, ZERO, MEM_READY;
  logic [3:0] IR_OPCODE;
  logic PC_LD, PC_INC, IR_LD, AR_LD, MEM_RD, MEM_WR, RF_WE, RF_SRC, HALTED, ERR;
  logic [2:0] ALU_OP;
  logic [15:0] INSTR_CNT;
  cpu_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .IR_OPCODE(IR_OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_LD(PC_LD), .PC_INC(PC_INC), .IR_LD(IR_LD), .AR_LD(AR_LD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .RF_WE(RF_WE), .RF_SRC(RF_SRC), .ALU_OP(ALU_OP), .HALTED(HALTED), .ERR(ERR), .INSTR_CNT(INSTR_CNT)
  );
  always #5 CLK = ~CLK;
  localparam logic [12:0] PCL = 13'h1000, PCI = 13'h0800, IRL = 13'h0400, ARL = 13'h0200, RD = 13'h0100,
    WR = 13'h0080, WE = 13'h0040, SRC = 13'h0020, H = 13'h0002, E = 13'h0001, FT = RD | IRL | PCI,
    A1 = 13'h0004, A4 = 13'h0010;
  typedef struct { logic [12:0] e; logic [15:0] c; string n; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [12:0] act;
  assign act = {PC_LD, PC_INC, IR_LD, AR_LD, MEM_RD, MEM_WR, RF_WE, RF_SRC, ALU_OP, HALTED, ERR};
  always @(negedge CLK) begin
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      checks++;
      if (act !== x.e || INSTR_CNT !== x.c) begin
        errors++;
        $display("FAIL %s: strobes=%h cnt=%0d, required strobes=%h cnt=%0d", x.n, act, INSTR_CNT, x.e, x.c);
      end
    end
  end
  task automatic step(input logic rn, input logic run, input logic [3:0] op, input logic z, input logic rdy,
                      input logic [12:0] e, input logic [15:0] c, input string n);
    exp_t x;
    RST_N = rn; RUN = run; IR_OPCODE = op; ZERO = z; MEM_READY = rdy;
    x.e = e; x.c = c; x.n = n;
    q.push_back(x);
    @(posedge CLK); #1;
  endtask
  initial begin
    RST_N = 1'b0; RUN = 1'b1; IR_OPCODE = 4'd0; ZERO = 1'b0; MEM_READY = 1'b0;
    @(posedge CLK); #1;
    step(0, 1, 4'h0, 0, 0, 13'h0, 0, "rst_hold");
    step(1, 1, 4'h0, 0, 0, 13'h0, 0, "idle_run");
    step(1, 0, 4'h1, 0, 1, FT, 0, "fetch_add");
    step(1, 0, 4'h1, 0, 1, 13'h0, 0, "dec_add");
    step(1, 0, 4'h1, 0, 1, WE, 1, "exec_add");
    step(1, 0, 4'h2, 0, 1, FT, 1, "fetch_sub");
    step(1, 0, 4'h2, 0, 1, 13'h0, 1, "dec_sub");
    step(1, 0, 4'h2, 0, 1, WE | A1, 2, "exec_sub");
    step(1, 0, 4'h5, 0, 1, FT, 2, "fetch_xor");
    step(1, 0, 4'h5, 0, 1, 13'h0, 2, "dec_xor");
    step(1, 0, 4'h5, 0, 1, WE | A4, 3, "exec_xor");
    step(1, 0, 4'h6, 0, 1, FT, 3, "fetch_ld");
    step(1, 0, 4'h6, 0, 1, 13'h0, 3, "dec_ld");
    step(1, 0, 4'h6, 0, 1, ARL, 4, "memaddr_ld");
    step(1, 0, 4'h6, 0, 0, RD, 4, "mem_ld_w0");
    step(1, 0, 4'h6, 0, 0, RD, 4, "mem_ld_w1");
    step(1, 0, 4'h6, 0, 0, RD, 4, "mem_ld_w2");
    step(1, 0, 4'h6, 0, 1, RD | WE | SRC, 4, "mem_ld_rdy");
    step(1, 0, 4'h7, 0, 1, FT, 4, "fetch_st");
    step(1, 0, 4'h7, 0, 1, 13'h0, 4, "dec_st");
    step(1, 0, 4'h7, 0, 0, ARL, 5, "memaddr_st");
    step(1, 0, 4'h7, 0, 0, WR, 5, "mem_st_w0");
    step(1, 0, 4'h7, 0, 1, WR, 5, "mem_st_rdy");
    step(1, 0, 4'h9, 1, 1, FT, 5, "fetch_bz");
    step(1, 0, 4'h9, 1, 1, 13'h0, 5, "dec_bz_taken");
    step(1, 0, 4'h9, 1, 1, PCL, 6, "branch_bz");
    step(1, 0, 4'h8, 0, 1, FT, 6, "fetch_jmp");
    step(1, 0, 4'h8, 0, 1, 13'h0, 6, "dec_jmp");
    step(1, 0, 4'h8, 0, 1, PCL, 7, "branch_jmp");
    step(1, 0, 4'h0, 0, 1, FT, 7, "fetch_nop");
    step(1, 0, 4'h0, 0, 1, 13'h0, 7, "dec_nop");
    step(1, 0, 4'h9, 0, 1, FT, 8, "fetch_bzn");
    step(1, 0, 4'h9, 0, 1, 13'h0, 8, "dec_bz_untaken");
    step(1, 0, 4'h9, 0, 0, RD, 9, "fetch_w0");
    step(1, 0, 4'h9, 0, 0, RD, 9, "fetch_w1");
    step(1, 0, 4'h9, 0, 0, RD, 9, "fetch_w2");
    step(1, 0, 4'h7, 0, 1, FT, 9, "fetch_last_rdy");
    step(1, 0, 4'h7, 0, 0, 13'h0, 9, "dec_st2");
    step(1, 0, 4'h7, 0, 0, ARL, 10, "memaddr_st2");
    step(1, 0, 4'h7, 0, 0, WR, 10, "mem_st_pend");
    step(0, 0, 4'h7, 0, 0, WR, 10, "rst_mid_st");
    step(1, 0, 4'h7, 0, 0, 13'h0, 0, "after_rst");
    step(1, 0, 4'h7, 0, 1, 13'h0, 0, "idle_no_run");
    step(1, 1, 4'h0, 0, 0, 13'h0, 0, "idle_run2");
    step(1, 0, 4'h0, 0, 0, RD, 0, "to_w0");
    step(1, 0, 4'h0, 0, 0, RD, 0, "to_w1");
    step(1, 0, 4'h0, 0, 0, RD, 0, "to_w2");
    step(1, 0, 4'h0, 0, 0, RD, 0, "to_w3");
    step(1, 0, 4'h0, 0, 1, H | E, 0, "to_halt");
    step(0, 0, 4'hF, 0, 0, H | E, 0, "rst_from_to");
    step(1, 1, 4'hF, 0, 0, 13'h0, 0, "idle_run3");
    step(1, 0, 4'hF, 0, 1, FT, 0, "fetch_hlt");
    step(1, 0, 4'hF, 0, 1, 13'h0, 0, "dec_hlt");
    step(1, 1, 4'hF, 0, 1, H, 1, "hlt_halt0");
    step(1, 0, 4'hF, 0, 0, H, 1, "hlt_halt1");
    step(0, 1, 4'hB, 0, 0, H, 1, "rst_from_hlt");
    step(1, 1, 4'hB, 0, 0, 13'h0, 0, "idle_run4");
    step(1, 0, 4'hB, 0, 1, FT, 0, "fetch_ill");
    step(1, 0, 4'hB, 0, 1, 13'h0, 0, "dec_ill");
    step(1, 1, 4'hB, 0, 1, H | E, 1, "ill_halt0");
    step(1, 0, 4'hB, 0, 1, H | E, 1, "ill_halt1");
    step(1, 1, 4'hB, 0, 0, H | E, 1, "ill_halt2");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
